busio_arbiter: RTL and testbench

- Shares the single external memory bus between the instruction-fetch port and the data load/store port.
- Produces the `fetch_ready` and `mem_ready` handshakes that the pipeline hazard/stall logic consumes.
- Sequences one transaction at a time through a small FSM.
- Fixed priority favours the data port, with a bounded-starvation guarantee for fetch.

---
 rtl/busio_arbiter_if.sv | 47 ++++
 rtl/busio_arbiter.sv | 108 ++++++++++
 tb/tb_busio_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/busio_arbiter_if.sv
// Handshake bundle between the pipeline ports, the arbiter and the external memory bus.
// master = arbiter side, slave = pipeline and memory environment side.
interface busio_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  fetch_valid;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  fetch_ready;

  logic                  mem_valid;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [STRB_WIDTH-1:0] mem_strobe;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  mem_ready;

  logic                  ext_valid;
  logic                  ext_write;
  logic [ADDR_WIDTH-1:0] ext_address;
  logic [DATA_WIDTH-1:0] ext_write_data;
  logic [STRB_WIDTH-1:0] ext_strobe;
  logic                  ext_ready;
  logic [DATA_WIDTH-1:0] ext_read_data;

  modport master (
    input  fetch_valid, fetch_address,
    output fetch_data, fetch_ready,
    input  mem_valid, mem_write, mem_address, mem_write_data, mem_strobe,
    output mem_read_data, mem_ready,
    output ext_valid, ext_write, ext_address, ext_write_data, ext_strobe,
    input  ext_ready, ext_read_data
  );

  modport slave (
    output fetch_valid, fetch_address,
    input  fetch_data, fetch_ready,
    output mem_valid, mem_write, mem_address, mem_write_data, mem_strobe,
    input  mem_read_data, mem_ready,
    input  ext_valid, ext_write, ext_address, ext_write_data, ext_strobe,
    output ext_ready, ext_read_data
  );
endinterface

// File: rtl/busio_arbiter.sv
// Shares the external memory bus between instruction fetch and data load/store,
// one transaction at a time, data first with a bounded wait for fetch.
//
// state   | meaning
// S_IDLE  | arbitrate between pending fetch and data requests
// S_FETCH | fetch read on the external bus, waiting for ext_ready
// S_MEM   | load/store on the external bus, waiting for ext_ready
// S_DONE  | one completion cycle; matching ready pulses, no arbitration
module busio_arbiter #(
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int FETCH_STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            reset,
  busio_arbiter_if.master bus
);
  localparam int         STRB_WIDTH   = DATA_WIDTH / 8;
  localparam logic [3:0] STARVE_LIMIT = 4'(FETCH_STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MEM, S_DONE} state_t;

  state_t                state, state_nxt;
  logic                  grant_fetch, grant_mem;
  logic                  starve_hit, fetch_match;
  logic [3:0]            starve_cnt;
  logic                  is_fetch_q, write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, fetch_data_q, mem_rdata_q;
  logic [STRB_WIDTH-1:0] strobe_q;

  assign starve_hit = (starve_cnt == STARVE_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_fetch = 1'b0;
    grant_mem   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.mem_valid && !(starve_hit && bus.fetch_valid)) begin
          grant_mem = 1'b1;
          state_nxt = S_MEM;
        end else if (bus.fetch_valid) begin
          grant_fetch = 1'b1;
          state_nxt   = S_FETCH;
        end
      end
      S_FETCH, S_MEM: if (bus.ext_ready) state_nxt = S_DONE;
      S_DONE:         state_nxt = S_IDLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Fetch and load requests always present full-word byte enables on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt   <= '0;
      is_fetch_q   <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strobe_q     <= '0;
      fetch_data_q <= '0;
      mem_rdata_q  <= '0;
    end else begin
      if (grant_mem) begin
        is_fetch_q <= 1'b0;
        write_q    <= bus.mem_write;
        addr_q     <= bus.mem_address;
        wdata_q    <= bus.mem_write_data;
        strobe_q   <= bus.mem_write ? bus.mem_strobe : '1;
        if (!bus.fetch_valid)  starve_cnt <= '0;
        else if (!starve_hit)  starve_cnt <= starve_cnt + 4'd1;
      end
      if (grant_fetch) begin
        is_fetch_q <= 1'b1;
        write_q    <= 1'b0;
        addr_q     <= bus.fetch_address;
        wdata_q    <= '0;
        strobe_q   <= '1;
        starve_cnt <= '0;
      end
      if (state == S_FETCH && bus.ext_ready)
        fetch_data_q <= bus.ext_read_data;
      if (state == S_MEM && bus.ext_ready && !write_q)
        mem_rdata_q <= bus.ext_read_data;
    end
  end

  // A fetch whose requester moved on or withdrew completes silently.
  assign fetch_match = bus.fetch_valid && (bus.fetch_address == addr_q);

  assign bus.ext_valid      = (state == S_FETCH) || (state == S_MEM);
  assign bus.ext_write      = write_q;
  assign bus.ext_address    = addr_q;
  assign bus.ext_write_data = wdata_q;
  assign bus.ext_strobe     = strobe_q;

  assign bus.fetch_data    = fetch_data_q;
  assign bus.mem_read_data = mem_rdata_q;
  assign bus.fetch_ready   = (state == S_DONE) && is_fetch_q && fetch_match;
  assign bus.mem_ready     = (state == S_DONE) && !is_fetch_q;
endmodule

// File: tb/tb_busio_arbiter.sv
// Scoreboard bench for busio_arbiter: directed scenarios plus randomized
// concurrent fetch and load/store traffic against a simple memory model.
module tb_busio_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  typedef struct {
    bit          is_store;
    logic [31:0] data;
  } mexp_t;

  logic clk;
  logic reset;

  busio_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  busio_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FETCH_STARVE_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] fetch_q[$];
  mexp_t       mem_q[$];
  bit          grant_log[$];
  logic [31:0] last_load = 32'h0;

  logic [31:0] bus_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  bit          resp_auto = 1'b0;
  int          resp_wait_max = 0;
  logic        auto_ready = 1'b0;
  logic [31:0] auto_rdata = 32'h0;
  logic        man_ready = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  bit          chk_auto = 1'b0;

  assign bus.ext_ready     = resp_auto ? auto_ready : man_ready;
  assign bus.ext_read_data = resp_auto ? auto_rdata : man_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] mem_init(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] bus_read(logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : mem_init(a);
  endfunction

  function automatic logic [31:0] ref_read(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // External memory device: random wait states, applies stores on completion.
  initial begin
    int wait_left;
    wait_left = -1;
    forever begin
      @(posedge clk);
      #1;
      auto_ready = 1'b0;
      if (resp_auto && bus.ext_valid && !reset) begin
        if (wait_left < 0) wait_left = $urandom_range(resp_wait_max, 0);
        if (wait_left == 0) begin
          auto_ready = 1'b1;
          if (bus.ext_write) begin
            bus_mem[bus.ext_address] = merge(bus_read(bus.ext_address), bus.ext_write_data, bus.ext_strobe);
            auto_rdata = $urandom;
          end else begin
            auto_rdata = bus_read(bus.ext_address);
          end
          wait_left = -1;
        end else begin
          wait_left--;
        end
      end else begin
        wait_left = -1;
      end
    end
  end

  // Monitor: scoreboard pops, bus stability, and arbitration rules.
  initial begin
    logic        pv_valid, pv_hs, pv_kind, cur_kind, p_fv, p_mv;
    logic [31:0] p_addr, p_wdata;
    logic        p_write;
    logic [3:0]  p_strb;
    int          run;
    mexp_t       e;
    pv_valid = 0; pv_hs = 0; pv_kind = 0; cur_kind = 0; p_fv = 0; p_mv = 0;
    p_addr = 0; p_wdata = 0; p_write = 0; p_strb = 0; run = 0;
    forever begin
      smp();
      if (reset) begin
        pv_valid = 0; pv_hs = 0; run = 0;
      end else begin
        if (bus.fetch_ready || bus.mem_ready)
          chk("ready_one_hot", {63'd0, bus.fetch_ready & bus.mem_ready}, 64'd0);
        if (bus.fetch_ready) begin
          if (fetch_q.size() == 0) chk("fetch_unexpected", bus.fetch_ready, 0);
          else chk("fetch_data", bus.fetch_data, fetch_q.pop_front());
        end
        if (bus.mem_ready) begin
          if (mem_q.size() == 0) chk("mem_unexpected", bus.mem_ready, 0);
          else begin
            e = mem_q.pop_front();
            if (e.is_store) chk("store_keeps_rdata", bus.mem_read_data, last_load);
            else begin
              chk("load_data", bus.mem_read_data, e.data);
              last_load = e.data;
            end
          end
        end
        if (bus.ext_valid && pv_valid && !pv_hs)
          chk("ext_stable", {bus.ext_address, bus.ext_write, bus.ext_strobe, bus.ext_write_data[26:0]},
              {p_addr, p_write, p_strb, p_wdata[26:0]});
        if (bus.ext_valid && bus.ext_ready && !bus.ext_write)
          chk("read_strobe", bus.ext_strobe, 4'hF);
        if (chk_auto) begin
          if (bus.ext_valid && !pv_valid) begin
            cur_kind = (bus.ext_address < 32'h1000);
            grant_log.push_back(cur_kind);
            if (!cur_kind) begin
              run = p_fv ? run + 1 : 0;
              chk("starve_bound", run <= LIMIT, 1);
            end else begin
              if (p_mv) chk("fetch_only_when_forced", run, LIMIT);
              run = 0;
            end
          end
          if (pv_hs) chk("ready_after_ext", {bus.fetch_ready, bus.mem_ready}, pv_kind ? 2'b10 : 2'b01);
          else if (bus.fetch_ready || bus.mem_ready)
            chk("ready_without_ext", {bus.fetch_ready, bus.mem_ready}, 2'b00);
        end
        pv_valid = bus.ext_valid;
        pv_hs    = bus.ext_valid && bus.ext_ready;
        pv_kind  = cur_kind;
        p_addr   = bus.ext_address;
        p_write  = bus.ext_write;
        p_strb   = bus.ext_strobe;
        p_wdata  = bus.ext_write_data;
        p_fv     = bus.fetch_valid;
        p_mv     = bus.mem_valid;
      end
    end
  end

  task automatic run_fetch(int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      int k;
      repeat ($urandom_range(3, 0)) cyc();
      a = 32'(4 * $urandom_range(255, 0));
      bus.fetch_address = a;
      bus.fetch_valid   = 1'b1;
      fetch_q.push_back(mem_init(a));
      k = 0;
      do begin smp(); k++; end while (!bus.fetch_ready && k < 200);
      if (!bus.fetch_ready) chk("fetch_timeout", bus.fetch_ready, 1);
      cyc();
      bus.fetch_valid = 1'b0;
    end
  endtask

  task automatic run_mem(int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, wd;
      logic [3:0]  st;
      bit          is_st;
      int          k;
      repeat ($urandom_range(3, 0)) cyc();
      is_st = 1'($urandom_range(1, 0));
      a     = 32'h1000 + 32'(4 * $urandom_range(15, 0));
      wd    = $urandom;
      st    = 4'($urandom_range(15, 0));
      bus.mem_write      = is_st;
      bus.mem_address    = a;
      bus.mem_write_data = wd;
      bus.mem_strobe     = st;
      bus.mem_valid      = 1'b1;
      if (is_st) begin
        ref_mem[a] = merge(ref_read(a), wd, st);
        mem_q.push_back('{1'b1, 32'h0});
      end else begin
        mem_q.push_back('{1'b0, ref_read(a)});
      end
      k = 0;
      do begin smp(); k++; end while (!bus.mem_ready && k < 200);
      if (!bus.mem_ready) chk("mem_timeout", bus.mem_ready, 1);
      cyc();
      bus.mem_valid = 1'b0;
    end
  endtask

  initial begin
    int k;
    reset = 1'b1;
    bus.fetch_valid = 0; bus.fetch_address = 0;
    bus.mem_valid = 0; bus.mem_write = 0; bus.mem_address = 0;
    bus.mem_write_data = 0; bus.mem_strobe = 0;

    // Reset values
    repeat (2) smp();
    chk("rst_ext_valid", bus.ext_valid, 0);
    chk("rst_ext_write", bus.ext_write, 0);
    chk("rst_fetch_ready", bus.fetch_ready, 0);
    chk("rst_mem_ready", bus.mem_ready, 0);
    chk("rst_ext_address", bus.ext_address, 0);
    chk("rst_ext_strobe", bus.ext_strobe, 0);
    chk("rst_fetch_data", bus.fetch_data, 0);
    chk("rst_mem_read_data", bus.mem_read_data, 0);
    cyc();
    reset = 1'b0;
    cyc();

    // Single fetch, zero wait states
    cyc();
    bus.fetch_valid = 1; bus.fetch_address = 32'h100;
    fetch_q.push_back(32'hDEAD_BEEF);
    smp();
    chk("fetch_t0_ext_valid", bus.ext_valid, 0);
    cyc();
    man_ready = 1; man_rdata = 32'hDEAD_BEEF;
    smp();
    chk("fetch_t1_ext_valid", bus.ext_valid, 1);
    chk("fetch_t1_ext_address", bus.ext_address, 32'h100);
    chk("fetch_t1_ext_strobe", bus.ext_strobe, 4'hF);
    chk("fetch_t1_ext_write", bus.ext_write, 0);
    cyc();
    man_ready = 0;
    smp();
    chk("fetch_t2_ready", bus.fetch_ready, 1);
    cyc();
    bus.fetch_valid = 0;

    // Data priority over fetch, then DONE gap before the fetch grant
    cyc();
    bus.mem_valid = 1; bus.mem_write = 1; bus.mem_address = 32'h200;
    bus.mem_write_data = 32'h1234_5678; bus.mem_strobe = 4'b0011;
    bus.fetch_valid = 1; bus.fetch_address = 32'h104;
    mem_q.push_back('{1'b1, 32'h0});
    fetch_q.push_back(32'hCAFE_F00D);
    smp();
    cyc();
    man_ready = 1; man_rdata = 32'h0BAD_0BAD;
    smp();
    chk("prio_ext_address", bus.ext_address, 32'h200);
    chk("prio_ext_write", bus.ext_write, 1);
    chk("prio_ext_strobe", bus.ext_strobe, 4'b0011);
    chk("prio_ext_wdata", bus.ext_write_data, 32'h1234_5678);
    cyc();
    man_ready = 0;
    smp();
    chk("prio_mem_ready", bus.mem_ready, 1);
    chk("prio_no_fetch_ready", bus.fetch_ready, 0);
    cyc();
    bus.mem_valid = 0;
    smp();
    chk("prio_done_gap", bus.ext_valid, 0);
    cyc();
    man_ready = 1; man_rdata = 32'hCAFE_F00D;
    smp();
    chk("prio_fetch_grant", bus.ext_valid, 1);
    chk("prio_fetch_address", bus.ext_address, 32'h104);
    cyc();
    man_ready = 0;
    smp();
    chk("prio_fetch_ready", bus.fetch_ready, 1);
    cyc();
    bus.fetch_valid = 0;

    // Withdrawn fetch: address moves before completion
    cyc();
    bus.fetch_valid = 1; bus.fetch_address = 32'h100;
    smp();
    cyc();
    bus.fetch_address = 32'h300;
    smp();
    chk("wd_latched_address", bus.ext_address, 32'h100);
    cyc();
    man_ready = 1; man_rdata = 32'h1111_1111;
    smp();
    cyc();
    man_ready = 0;
    fetch_q.push_back(32'h3333_3333);
    smp();
    chk("wd_no_ready", bus.fetch_ready, 0);
    cyc();
    smp();
    chk("wd_idle_gap", bus.ext_valid, 0);
    cyc();
    man_ready = 1; man_rdata = 32'h3333_3333;
    smp();
    chk("wd_regrant_address", bus.ext_address, 32'h300);
    cyc();
    man_ready = 0;
    smp();
    chk("wd_regrant_ready", bus.fetch_ready, 1);
    cyc();
    bus.fetch_valid = 0;

    // Wait states: five cycles without ext_ready
    cyc();
    bus.mem_valid = 1; bus.mem_write = 0; bus.mem_address = 32'h204;
    mem_q.push_back('{1'b0, 32'h55AA_55AA});
    smp();
    for (int i = 0; i < 5; i++) begin
      cyc();
      smp();
      chk("ws_ext_valid", bus.ext_valid, 1);
      chk("ws_ext_address", bus.ext_address, 32'h204);
      chk("ws_no_ready", bus.mem_ready, 0);
    end
    cyc();
    man_ready = 1; man_rdata = 32'h55AA_55AA;
    smp();
    cyc();
    man_ready = 0;
    smp();
    chk("ws_mem_ready", bus.mem_ready, 1);
    cyc();
    bus.mem_valid = 0;
    smp();
    chk("ws_single_pulse", bus.mem_ready, 0);

    // Starvation bound with both requesters held
    cyc();
    resp_auto = 1; resp_wait_max = 0; chk_auto = 1;
    grant_log.delete();
    bus.fetch_valid = 1; bus.fetch_address = 32'h108;
    bus.mem_valid = 1; bus.mem_write = 0; bus.mem_address = 32'h1004;
    for (int i = 0; i < LIMIT; i++) mem_q.push_back('{1'b0, ref_read(32'h1004)});
    fetch_q.push_back(mem_init(32'h108));
    k = 0;
    do begin smp(); k++; end while (!bus.fetch_ready && k < 80);
    if (!bus.fetch_ready) chk("starve_timeout", bus.fetch_ready, 1);
    cyc();
    bus.fetch_valid = 0; bus.mem_valid = 0;
    repeat (3) cyc();
    chk("starve_grant_count", grant_log.size(), LIMIT + 1);
    for (int i = 0; i < grant_log.size() && i <= LIMIT; i++)
      chk("starve_grant_order", grant_log[i], (i == LIMIT) ? 1 : 0);
    resp_auto = 0; chk_auto = 0;

    // Reset in the middle of a store
    cyc();
    bus.mem_valid = 1; bus.mem_write = 1; bus.mem_address = 32'h208;
    bus.mem_write_data = 32'hABCD; bus.mem_strobe = 4'hF;
    smp();
    cyc();
    smp();
    chk("rmid_ext_valid_before", bus.ext_valid, 1);
    #1;
    reset = 1; bus.mem_valid = 0;
    #1;
    chk("rmid_ext_valid_async", bus.ext_valid, 0);
    chk("rmid_ext_address", bus.ext_address, 0);
    cyc();
    cyc();
    reset = 0; last_load = 32'h0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("rmid_no_mem_ready", bus.mem_ready, 0);
      chk("rmid_no_ext_valid", bus.ext_valid, 0);
    end

    // Randomized concurrent traffic
    cyc();
    resp_auto = 1; resp_wait_max = 3; chk_auto = 1;
    fork
      run_fetch(60);
      run_mem(60);
    join
    repeat (5) cyc();
    chk("fetch_q_drained", fetch_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
